// File: rtl/alu_exec_unit_pkg.sv
// alu_pkg: shared types for the multi-cycle ALU execution unit.
// Holds the 4-bit operation encoding, the FSM state enum, the
// branch-condition bundle and small decode helpers.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SLTU = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SUBU = 4'b0111,
        OP_SRL  = 4'b1000,
        OP_SLT  = 4'b1010,
        OP_SRA  = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } alu_state_e;

    typedef enum logic [1:0] {
        SH_LL,
        SH_RL,
        SH_RA
    } shift_kind_e;

    // Branch-condition flags captured together with the operands.
    typedef struct packed {
        logic beq;
        logic bnq;
        logic blt;
        logic bgt;
    } br_cond_t;

    // Codes with no assigned operation.
    function automatic logic is_illegal_op(input logic [ALU_OP_W-1:0] code);
        return (code == 4'b1001) || (code == 4'b1011) || (code == 4'b1101) ||
               (code == 4'b1110) || (code == 4'b1111);
    endfunction

    function automatic logic is_shift_op(input logic [ALU_OP_W-1:0] code);
        return (code == OP_SLL) || (code == OP_SRL) || (code == OP_SRA);
    endfunction

    function automatic shift_kind_e shift_kind_of(input logic [ALU_OP_W-1:0] code);
        case (code)
            OP_SRL:  return SH_RL;
            OP_SRA:  return SH_RA;
            default: return SH_LL;
        endcase
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle for alu_exec_unit.
// master = issuing stage (decode), slave = the execution unit.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       Operation;
    logic             Con_beq;
    logic             Con_bnq;
    logic             Con_blt;
    logic             Con_bgt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             branch_taken;
    logic             op_illegal;

    modport master (
        output in_valid, Operation, Con_beq, Con_bnq, Con_blt, Con_bgt,
               op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, branch_taken, op_illegal
    );

    modport slave (
        input  in_valid, Operation, Con_beq, Con_bnq, Con_blt, Con_bgt,
               op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, branch_taken, op_illegal
    );
endinterface

// File: rtl/alu_serial_shifter.sv
// alu_serial_shifter: one-bit-per-cycle shifter with a down-counter.
// Loaded with the operand and shift amount; busy stays high until the
// requested number of single-bit shifts has been applied.
// Used only when ALU_FAST_SHIFT_EN is not defined.
module alu_serial_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  shift_kind_e        kind_in,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt_in,
    output logic               busy,
    output logic [WIDTH-1:0]   data_out
);

    logic [WIDTH-1:0]   data_q;
    logic [SHAMT_W-1:0] count_q;
    shift_kind_e        kind_q;

    // Load on request, otherwise shift one bit and count down while nonzero.
    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            count_q <= '0;
            kind_q  <= SH_LL;
        end else if (load) begin
            data_q  <= data_in;
            count_q <= shamt_in;
            kind_q  <= kind_in;
        end else if (count_q != '0) begin
            count_q <= count_q - SHAMT_W'(1);
            case (kind_q)
                SH_RL:   data_q <= {1'b0, data_q[WIDTH-1:1]};
                SH_RA:   data_q <= {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                default: data_q <= {data_q[WIDTH-2:0], 1'b0};
            endcase
        end
    end

    assign busy     = (count_q != '0);
    assign data_out = data_q;

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle ALU between decode and writeback.
// IDLE captures operands, EXEC computes (one cycle, or 1+shamt cycles for
// serial shifts), DONE holds the registered result until out_ready.
// Build option: define ALU_FAST_SHIFT_EN to replace the serial shifter
// with a combinational barrel shifter (shifts then take one EXEC cycle).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic           clk,
    input  logic           reset_n,
    alu_exec_unit_if.slave bus
);

    alu_state_e       state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    br_cond_t         cond_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             br_q;
    logic             ill_q;

    logic [WIDTH-1:0] shift_res;
    logic             exec_done;
    logic [WIDTH-1:0] alu_res;
    logic             br_next;
    logic             eq;
    logic             lt;

`ifdef ALU_FAST_SHIFT_EN
    logic [SHAMT_W-1:0] shamt;
    assign shamt     = b_q[SHAMT_W-1:0];
    assign exec_done = 1'b1;

    // Barrel shift of the captured operand.
    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        shift_res = a_q << shamt;
        case (op_q)
            OP_SRL:  shift_res = a_q >> shamt;
            OP_SRA:  shift_res = $signed(a_q) >>> shamt;
            default: shift_res = a_q << shamt;
        endcase
    end
`else
    logic sh_busy;
    logic sh_load;

    // The shifter is loaded on the accept edge so the first EXEC cycle already shifts.
    assign sh_load   = (state == S_IDLE) && bus.in_valid && is_shift_op(bus.Operation);
    assign exec_done = !sh_busy;

    alu_serial_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (sh_load),
        .kind_in  (shift_kind_of(bus.Operation)),
        .data_in  (bus.op_a),
        .shamt_in (bus.op_b[SHAMT_W-1:0]),
        .busy     (sh_busy),
        .data_out (shift_res)
    );
`endif

    // Result and branch decision from the captured operands.
    always_comb begin
        eq      = (a_q == b_q);
        lt      = (op_q == OP_SUBU) ? (a_q < b_q) : ($signed(a_q) < $signed(b_q));
        br_next = 1'b0;
        alu_res = '0;
        case (op_q)
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB, OP_SUBU: begin
                alu_res = a_q - b_q;
                br_next = (cond_q.beq & eq) | (cond_q.bnq & !eq) |
                          (cond_q.blt & lt) | (cond_q.bgt & !lt);
            end
            OP_SLT:  alu_res = WIDTH'($signed(a_q) < $signed(b_q));
            OP_SLTU: alu_res = WIDTH'(a_q < b_q);
            OP_SLL, OP_SRL, OP_SRA: alu_res = shift_res;
            default: alu_res = '0;
        endcase
    end

    // Control FSM with registered capture and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cond_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            br_q        <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_q   <= bus.Operation;
                        a_q    <= bus.op_a;
                        b_q    <= bus.op_b;
                        cond_q <= '{beq: bus.Con_beq, bnq: bus.Con_bnq,
                                    blt: bus.Con_blt, bgt: bus.Con_bgt};
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        result_q    <= alu_res;
                        zero_q      <= (alu_res == '0);
                        br_q        <= br_next;
                        ill_q       <= is_illegal_op(op_q);
                        out_valid_q <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready     = (state == S_IDLE);
    assign bus.out_valid    = out_valid_q;
    assign bus.result       = result_q;
    assign bus.zero         = zero_q;
    assign bus.branch_taken = br_q;
    assign bus.op_illegal   = ill_q;

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execution unit that consumes the 4-bit `Operation` code and branch-condition flags produced by the ALU controller and returns a 32-bit result, zero flag and branch decision. It sits between decode and writeback in the single-cycle core's FPGA build. Operand capture, result delivery and stalls use valid/ready handshakes, so the core can stall on long shifts. Add, subtract, logic and compare ops finish in one cycle; shifts use a serial shifter unless the fast-shift option is compiled in.

## Interface
- `WIDTH`, 32, operand/result width.
- `SHAMT_W`, 5, shift-amount width; must equal log2(`WIDTH`).
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands and op presented.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `Operation`  in  4  op code (encoding under Operation).
- `Con_beq`, `Con_bnq`, `Con_blt`, `Con_bgt`  in  1 each  branch-condition flags, captured with the operands.
- `op_a`, `op_b`  in  `WIDTH` each  operands; shift amount is `op_b[SHAMT_W-1:0]`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  `WIDTH`  ALU result.
- `zero`  out  1  `result == 0`.
- `branch_taken`  out  1  branch decision.
- `op_illegal`  out  1  captured code is undefined.

## Operation
- Encoding: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SLTU, 0110 SUB, 0111 SUBU (unsigned compare), 1000 SRL, 1010 SLT, 1100 SRA. The codes 1001, 1011, 1101, 1110 and 1111 are illegal.
- For an illegal code: `result`=0, `zero`=1, `op_illegal`=1, `branch_taken`=0, single-cycle latency.
- Arithmetic wraps modulo 2^`WIDTH`. SLT/SLTU return 0 or 1, zero-extended. SRA replicates `op_a[WIDTH-1]`.
- Flags:
  - `lt` is the signed compare for SUB and the unsigned compare for SUBU.
  - `eq` is `op_a==op_b`.
  - `branch_taken` = (beq&eq) | (bnq&!eq) | (blt&lt) | (bgt&!lt).
  - For any code other than SUB or SUBU, `branch_taken`=0.
- FSM IDLE -> EXEC -> DONE -> IDLE:
  - IDLE: `in_ready`=1. On `in_valid`, capture operands, op and flags, then go to EXEC.
  - EXEC, non-shift op: one cycle, register outputs, go to DONE.
  - EXEC, shift op: load the shifter and count `shamt` down by one bit per cycle. Go to DONE when the count reaches 0. `shamt`=0 still spends one EXEC cycle.
  - DONE: `out_valid`=1 and outputs hold stable. On `out_ready`, go to IDLE.
- Inputs are ignored outside IDLE.

## Timing
- Reset: state IDLE; `out_valid`, `result`, `zero`, `branch_taken`, `op_illegal` all 0; `in_ready`=1 after reset deassertion.
- Latency (accept edge to `out_valid` high):
  - Non-shift op: 2 edges.
  - Serial shift: 2 + `shamt` edges, so 33 worst case.
- Throughput is one op per 3 cycles minimum, because DONE->IDLE costs one cycle.
- `out_ready` held high in DONE: `out_valid` is high for exactly one cycle.
- `out_valid` held with `out_ready` low: outputs do not change.
- Reset mid-EXEC or mid-DONE: immediate return to IDLE, outputs cleared, the in-flight op is dropped.

## Configuration
- `ALU_FAST_SHIFT_EN` defined:
  - Shifts use a combinational barrel shifter and have the same latency as other ops.
  - The shift counter is removed.
- `ALU_FAST_SHIFT_EN` undefined: serial shifter as above.
- Results are identical in both builds; only latency differs.

## Structure
- Package `alu_pkg` holds:
  - The `alu_op_e` enum carrying the 4-bit encoding above.
  - The FSM state enum.
  - A function flagging illegal codes.
- Sub-module `alu_serial_shifter` holds the load/shift/count datapath with a `busy` output. It is instantiated only when `ALU_FAST_SHIFT_EN` is undefined.

## Test plan
- ADD `op_a`=0xFFFFFFFF, `op_b`=1 -> `result`=0, `zero`=1, `out_valid` 2 edges after accept.
- SUB with `Con_blt`=1, `op_a`=-5, `op_b`=3 -> `branch_taken`=1. The same operands with SUBU -> `branch_taken`=0.
- SRA `op_a`=0x80000000, `shamt`=31 -> 0xFFFFFFFF; serial latency 33, fast latency 2. SLL with `shamt`=0 returns `op_a` unchanged.
- `out_ready` low for 5 cycles in DONE -> `result` stable, `in_ready`=0, and a new `in_valid` is ignored.
- `Operation`=1011 -> `op_illegal`=1, `result`=0, `branch_taken`=0.
- `reset_n` asserted at cycle 10 of a 20-bit serial shift -> IDLE, all outputs 0. The next ADD 2+3 -> 5.
